// File: rtl/pirdsp_mac_accumulator.sv
// pirdsp_mac_accumulator: resolves PIRDSP partial products and accumulates them as one
// wide value (27x27 mode) or three independent lanes (sum-of-9x9 mode), two-cycle latency.
// Optional macro PIRDSP_ACC_SAT_EN: saturate on overflow instead of wrapping.
module pirdsp_mac_accumulator #(
    parameter int LANE_W = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic                mode,
    input  logic                in_signed,
    input  logic                acc_clear,
    input  logic [53:0]         result_0,
    input  logic [53:0]         result_1,
    input  logic [5:0]          result_SIMD_carry,
    output logic [3*LANE_W-1:0] acc_out,
    output logic                out_valid,
    output logic [2:0]          overflow
);
    localparam int AW = 3 * LANE_W;

    logic        s1_valid, s1_mode, s1_signed, s1_clear, prev_mode;
    logic [53:0] s1_r0, s1_r1;
    logic [5:0]  s1_carry;

    // S1 capture: data holds while idle, valid bit follows in_valid
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid  <= 1'b0;
            s1_mode   <= 1'b0;
            s1_signed <= 1'b0;
            s1_clear  <= 1'b0;
            s1_r0     <= '0;
            s1_r1     <= '0;
            s1_carry  <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mode   <= mode;
                s1_signed <= in_signed;
                s1_clear  <= acc_clear;
                s1_r0     <= result_0;
                s1_r1     <= result_1;
                s1_carry  <= result_SIMD_carry;
            end
        end
    end

    logic [53:0]   p54;
    logic [AW-1:0] p_full;
    logic [AW:0]   f_sum;
    logic          f_ov;
    logic [AW-1:0] f_res;

    assign p54    = s1_r0 + s1_r1;
    assign p_full = s1_signed ? AW'($signed(p54)) : AW'(p54);
    assign f_sum  = {1'b0, acc_out} + {1'b0, p_full};
    assign f_ov   = s1_signed ? (acc_out[AW-1] == p_full[AW-1]) && (f_sum[AW-1] != acc_out[AW-1])
                              : f_sum[AW];
`ifdef PIRDSP_ACC_SAT_EN
    assign f_res  = !f_ov ? f_sum[AW-1:0]
                  : s1_signed ? {acc_out[AW-1], {(AW-1){~acc_out[AW-1]}}} : '1;
`else
    assign f_res  = f_sum[AW-1:0];
`endif

    logic [LANE_W-1:0] l_ext [3];
    logic [LANE_W-1:0] l_res [3];
    logic [2:0]        l_ov;

    for (genvar k = 0; k < 3; k++) begin : g_lane
        logic [19:0]       l20;
        logic [LANE_W-1:0] a;
        logic [LANE_W:0]   sum;
        // Lane product: extended low vector plus carry-augmented high vector, kept to 20 bits
        assign l20 = (s1_signed ? 20'($signed(s1_r0[18*k +: 18])) : 20'(s1_r0[18*k +: 18]))
                   + {s1_carry[2*k +: 2], s1_r1[18*k +: 18]};
        assign l_ext[k] = s1_signed ? LANE_W'($signed(l20)) : LANE_W'(l20);
        assign a        = acc_out[k*LANE_W +: LANE_W];
        assign sum      = {1'b0, a} + {1'b0, l_ext[k]};
        assign l_ov[k]  = s1_signed ? (a[LANE_W-1] == l_ext[k][LANE_W-1]) && (sum[LANE_W-1] != a[LANE_W-1])
                                    : sum[LANE_W];
`ifdef PIRDSP_ACC_SAT_EN
        assign l_res[k] = !l_ov[k] ? sum[LANE_W-1:0]
                        : s1_signed ? {a[LANE_W-1], {(LANE_W-1){~a[LANE_W-1]}}} : '1;
`else
        assign l_res[k] = sum[LANE_W-1:0];
`endif
    end

    logic          load;
    logic [AW-1:0] acc_nxt;
    logic [2:0]    ov_nxt;

    // A mode change forces a load so lanes never inherit a wide value or vice versa
    assign load = s1_clear || (s1_mode != prev_mode);

    // Select add or load result for the active mode; loads clear sticky overflow
    always_comb begin
        acc_nxt = s1_mode ? {l_res[2], l_res[1], l_res[0]} : f_res;
        ov_nxt  = overflow | (s1_mode ? l_ov : {2'b00, f_ov});
        if (load) begin
            acc_nxt = s1_mode ? {l_ext[2], l_ext[1], l_ext[0]} : p_full;
            ov_nxt  = '0;
        end
    end

    // S2 accumulator register, fed back combinationally for bubble-free accumulation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_out   <= '0;
            overflow  <= '0;
            out_valid <= 1'b0;
            prev_mode <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                acc_out   <= acc_nxt;
                overflow  <= ov_nxt;
                prev_mode <= s1_mode;
            end
        end
    end

endmodule
